// File: rtl/aes_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the AES inverse-cipher controller.
package aes_pkg;

  localparam int unsigned AES_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam logic [BYTE_W-1:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant: sum of a, 2a, 4a, 8a selected by the bits of m.
  function automatic logic [BYTE_W-1:0] gmul(input logic [BYTE_W-1:0] a, input logic [3:0] m);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] acc;
    p   = a;
    acc = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (m[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [WORD_W-1:0] inv_mix_col(input logic [WORD_W-1:0] col);
    logic [BYTE_W-1:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Block, plaintext and round-key handshake bundle between the controller and its surroundings.
interface aes_inv_round_ctrl_if;
  logic                      in_valid;
  logic                      in_ready;
  logic [aes_pkg::AES_W-1:0] in_data;
  logic [3:0]                key_idx;
  logic [aes_pkg::AES_W-1:0] key_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [aes_pkg::AES_W-1:0] out_data;
  logic                      busy;

  modport master (
    output in_valid, in_data, key_in, out_ready,
    input  in_ready, key_idx, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, key_in, out_ready,
    output in_ready, key_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [AES_W-1:0] s,
  input  logic [AES_W-1:0] key,
  input  logic             last,
  output logic [AES_W-1:0] r
);
  logic [AES_W-1:0] ark;
  logic [AES_W-1:0] mixed;

  // Byte i sits at row i%4, column i/4; row n is rotated right by n columns.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int unsigned ROW = i % 4;
    localparam int unsigned COL = i / 4;
    localparam int unsigned SRC = ROW + 4 * ((COL + 4 - ROW) % 4);
    assign ark[AES_W-1-BYTE_W*i -: BYTE_W] =
      INV_SBOX[s[AES_W-1-BYTE_W*SRC -: BYTE_W]] ^ key[AES_W-1-BYTE_W*i -: BYTE_W];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mixed[AES_W-1-WORD_W*c -: WORD_W] = inv_mix_col(ark[AES_W-1-WORD_W*c -: WORD_W]);
  end

  assign r = last ? ark : mixed;
endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer, one round per cycle with round keys fetched by index.
// Optional AES_INV_ABORT_EN adds an abort input that drops the block in progress.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = NR_128
) (
  input logic clk,
  input logic rst,
`ifdef AES_INV_ABORT_EN
  input logic abort,
`endif
  aes_inv_round_ctrl_if.slave bus
);
  state_t           state, state_nx;
  logic [AES_W-1:0] sreg;
  logic [AES_W-1:0] round_out;
  logic [3:0]       rnd;
  logic             abort_i;

  if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_nr_check
    $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
  end

`ifdef AES_INV_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  aes_inv_round u_round (
    .s    (sreg),
    .key  (bus.key_in),
    .last (state == FINAL),
    .r    (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.in_valid) state_nx = ROUND;
      ROUND: if (rnd == 4'd1) state_nx = FINAL;
      FINAL: state_nx = DONE;
      DONE:  if (bus.out_ready) state_nx = IDLE;
    endcase
    if (abort_i && state != IDLE) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || (abort_i && state != IDLE)) begin
      sreg <= '0;
      rnd  <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          sreg <= bus.in_data ^ bus.key_in;
          rnd  <= 4'(NR - 1);
        end
        ROUND: begin
          sreg <= round_out;
          rnd  <= rnd - 4'd1;
        end
        FINAL: sreg <= round_out;
        DONE:  ;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b1;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.key_idx   = 4'(NR);
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      ROUND: bus.key_idx = rnd;
      FINAL: bus.key_idx = '0;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = sreg;
      end
    endcase
  end
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl using the FIPS-197 known-answer blocks for NR = 10, 12, 14.
// The abort scenario is built only when AES_INV_ABORT_EN is defined.
module tb_aes_inv_round_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] in_data = '0;
  int unsigned  sel = 0;
  int unsigned  cycle = 0;
  int unsigned  errors = 0;
  int unsigned  checks = 0;

  logic [127:0] rk10 [16];
  logic [127:0] rk12 [16];
  logic [127:0] rk14 [16];
  logic [31:0]  w [60];

  logic         o_in_ready, o_out_valid, o_busy;
  logic [3:0]   o_key_idx;
  logic [127:0] o_out_data;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  aes_inv_round_ctrl_if if10 ();
  aes_inv_round_ctrl_if if12 ();
  aes_inv_round_ctrl_if if14 ();

  assign if10.in_valid  = in_valid && sel == 0;
  assign if12.in_valid  = in_valid && sel == 1;
  assign if14.in_valid  = in_valid && sel == 2;
  assign if10.out_ready = out_ready && sel == 0;
  assign if12.out_ready = out_ready && sel == 1;
  assign if14.out_ready = out_ready && sel == 2;
  assign if10.in_data   = in_data;
  assign if12.in_data   = in_data;
  assign if14.in_data   = in_data;
  assign if10.key_in    = rk10[if10.key_idx];
  assign if12.key_in    = rk12[if12.key_idx];
  assign if14.key_in    = rk14[if14.key_idx];

  aes_inv_round_ctrl #(.NR(10)) u_dut10 (
    .clk (clk),
    .rst (rst),
`ifdef AES_INV_ABORT_EN
    .abort (abort && sel == 0),
`endif
    .bus (if10)
  );
  aes_inv_round_ctrl #(.NR(12)) u_dut12 (
    .clk (clk),
    .rst (rst),
`ifdef AES_INV_ABORT_EN
    .abort (abort && sel == 1),
`endif
    .bus (if12)
  );
  aes_inv_round_ctrl #(.NR(14)) u_dut14 (
    .clk (clk),
    .rst (rst),
`ifdef AES_INV_ABORT_EN
    .abort (abort && sel == 2),
`endif
    .bus (if14)
  );

  always_comb begin
    case (sel)
      0: {o_in_ready, o_out_valid, o_busy, o_key_idx, o_out_data} =
           {if10.in_ready, if10.out_valid, if10.busy, if10.key_idx, if10.out_data};
      1: {o_in_ready, o_out_valid, o_busy, o_key_idx, o_out_data} =
           {if12.in_ready, if12.out_valid, if12.busy, if12.key_idx, if12.out_data};
      default: {o_in_ready, o_out_valid, o_busy, o_key_idx, o_out_data} =
           {if14.in_ready, if14.out_valid, if14.busy, if14.key_idx, if14.out_data};
    endcase
  end

  function automatic logic [7:0] tb_xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [127:0] rk_of(input int unsigned r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic expand(input logic [255:0] key, input int unsigned nk, input int unsigned nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int unsigned i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = tb_xtime(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
  endtask

  // One block through instance s, optionally stalling in DONE or toggling in_valid mid-flight.
  task automatic run_block(input int unsigned s, input int unsigned nr, input logic [127:0] ct,
                           input int unsigned stall, input bit noise, output int unsigned hs);
    int unsigned cyc;
    sel = s;
    #1;
    checks++;
    if (o_in_ready !== 1'b1 || o_key_idx !== 4'(nr)) begin
      errors++;
      $display("FAIL idle_nr%0d: in_ready=%b key_idx=%0d, want 1 and %0d", nr, o_in_ready, o_key_idx, nr);
    end
    in_valid = 1'b1;
    in_data  = ct;
    hs       = cycle;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (o_out_valid !== 1'b1 && cyc < 40) begin
      if (cyc <= nr) begin
        checks++;
        if (o_key_idx !== 4'(nr - cyc) || o_in_ready !== 1'b0 || o_busy !== 1'b1 || o_out_data !== '0) begin
          errors++;
          $display("FAIL run_nr%0d_c%0d: key_idx=%0d in_ready=%b busy=%b out_data=%h, want %0d 0 1 0",
                   nr, cyc, o_key_idx, o_in_ready, o_busy, o_out_data, nr - cyc);
        end
      end
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (cyc !== nr + 1) begin
      errors++;
      $display("FAIL latency_nr%0d: out_valid at cycle %0d, want %0d", nr, cyc, nr + 1);
    end
    checks++;
    if (o_out_valid !== 1'b1 || o_out_data !== PT) begin
      errors++;
      $display("FAIL data_nr%0d: out_valid=%b out_data=%h, want 1 %h", nr, o_out_valid, o_out_data, PT);
    end
    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (o_out_valid !== 1'b1 || o_out_data !== PT || o_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_nr%0d_%0d: out_valid=%b out_data=%h in_ready=%b, want 1 %h 0",
                 nr, i, o_out_valid, o_out_data, o_in_ready, PT);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_out_data !== '0 || o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL release_nr%0d: out_valid=%b out_data=%h in_ready=%b busy=%b, want 0 0 1 0",
               nr, o_out_valid, o_out_data, o_in_ready, o_busy);
    end
  endtask

  task automatic test_reset;
    for (int unsigned s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_out_data !== '0 || o_busy !== 1'b0 ||
          o_key_idx !== 4'(10 + 2 * s)) begin
        errors++;
        $display("FAIL reset_%0d: in_ready=%b out_valid=%b out_data=%h busy=%b key_idx=%0d, want 1 0 0 0 %0d",
                 s, o_in_ready, o_out_valid, o_out_data, o_busy, o_key_idx, 10 + 2 * s);
      end
    end
  endtask

  task automatic test_decrypt;
    int unsigned hs;
    run_block(0, 10, CT10, 0, 1'b0, hs);
    run_block(1, 12, CT12, 0, 1'b0, hs);
    run_block(2, 14, CT14, 0, 1'b0, hs);
  endtask

  task automatic test_stall;
    int unsigned hs;
    run_block(0, 10, CT10, 20, 1'b0, hs);
  endtask

  task automatic test_input_noise;
    int unsigned hs;
    run_block(0, 10, CT10, 0, 1'b1, hs);
  endtask

  task automatic test_back_to_back;
    int unsigned hs1, hs2;
    run_block(0, 10, CT10, 0, 1'b0, hs1);
    run_block(0, 10, CT10, 0, 1'b0, hs2);
    checks++;
    if (hs2 - hs1 !== 12) begin
      errors++;
      $display("FAIL spacing: %0d cycles between accepts, want 12", hs2 - hs1);
    end
  endtask

  task automatic test_mid_reset;
    int unsigned hs;
    bit seen;
    sel = 0;
    #1;
    in_valid = 1'b1;
    in_data  = CT10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_out_data !== '0 || o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b out_data=%h in_ready=%b, want 0 0 1",
               o_out_valid, o_out_data, o_in_ready);
    end
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (o_out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ghost: out_valid seen=%b, want 0", seen);
    end
    run_block(0, 10, CT10, 0, 1'b0, hs);
  endtask

`ifdef AES_INV_ABORT_EN
  task automatic test_abort;
    int unsigned hs;
    bit seen;
    sel = 0;
    #1;
    in_valid = 1'b1;
    in_data  = CT10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_final: in_ready=%b out_valid=%b, want 1 0", o_in_ready, o_out_valid);
    end
    seen = 1'b0;
    repeat (13) begin
      @(negedge clk);
      if (o_out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_ghost: out_valid seen=%b, want 0", seen);
    end
    in_valid = 1'b1;
    in_data  = CT10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (o_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach_done: out_valid=%b, want 1", o_out_valid);
    end
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_out_data !== '0 || o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_done: out_valid=%b out_data=%h in_ready=%b, want 0 0 1",
               o_out_valid, o_out_data, o_in_ready);
    end
    run_block(0, 10, CT10, 0, 1'b0, hs);
  endtask
`endif

  initial begin
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    for (int unsigned r = 0; r <= 10; r++) rk10[r] = rk_of(r);
    expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    for (int unsigned r = 0; r <= 12; r++) rk12[r] = rk_of(r);
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    for (int unsigned r = 0; r <= 14; r++) rk14[r] = rk_of(r);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_decrypt;
    test_stall;
    test_input_noise;
    test_back_to_back;
    test_mid_reset;
`ifdef AES_INV_ABORT_EN
    test_abort;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
